ipv4_tx_framer: RTL and testbench

IPV4_TX_FRAMER -- requirements
Module: ipv4_tx_framer

---
 rtl/ipv4_tx_framer_pkg.sv | 27 ++
 rtl/ipv4_hdr_csum.sv | 42 ++++
 rtl/ipv4_tx_framer.sv | 164 ++++++++++++++++
 tb/tb_ipv4_tx_framer.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/ipv4_tx_framer_pkg.sv
// Shared definitions for the IPv4 transmit framer.
//   state_t    : framer FSM states
//   HDR_WORDS  : 16-bit words in an option-less IPv4 header
//   HDR_BYTES  : header length in bytes
//   CSUM_LAT   : cycles from latched fields to a valid checksum
//   VER_IHL    : version 4, IHL 5, TOS 0
package ipv4_tx_framer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CSUM    = 2'd1,
    ST_HDR     = 2'd2,
    ST_PAYLOAD = 2'd3
  } state_t;

  localparam int unsigned HDR_WORDS  = 10;
  localparam int unsigned HDR_BYTES  = 2 * HDR_WORDS;
  localparam int unsigned CSUM_LAT   = 3;
  localparam logic [15:0] VER_IHL    = 16'h4500;
  localparam logic [15:0] IP_HDR_LEN = 16'd20;

  // Big-endian byte select within a header word.
  function automatic logic [7:0] word_byte(input logic [15:0] w, input logic lo);
    return lo ? w[7:0] : w[15:8];
  endfunction

endpackage

// File: rtl/ipv4_hdr_csum.sv
// IPv4 header checksum, three register stages.
//   clk, rst_n : clock, synchronous active-low reset
//   fields     : the nine header words other than the checksum itself
//   csum       : ~(ones'-complement sum of fields), valid CSUM_LAT cycles
//                after fields settle
module ipv4_hdr_csum
  import ipv4_tx_framer_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] fields [HDR_WORDS-1],
  output logic [15:0] csum
);

  logic [16:0] pair_q [5];
  logic [19:0] total_q;
  logic [16:0] fold1;
  logic [15:0] fold2;

  // Two folds are enough: the first leaves at most 0x1000E, whose carry
  // cannot ripple again once added back.
  always_comb begin
    fold1 = {1'b0, total_q[15:0]} + {13'b0, total_q[19:16]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 5; i++) pair_q[i] <= '0;
      total_q <= '0;
      csum    <= '0;
    end else begin
      for (int unsigned i = 0; i < 4; i++)
        pair_q[i] <= {1'b0, fields[2*i]} + {1'b0, fields[2*i+1]};
      pair_q[4] <= {1'b0, fields[8]};
      total_q   <= {3'b0, pair_q[0]} + {3'b0, pair_q[1]} + {3'b0, pair_q[2]}
                 + {3'b0, pair_q[3]} + {3'b0, pair_q[4]};
      csum      <= ~fold2;
    end
  end

endmodule

// File: rtl/ipv4_tx_framer.sv
// IPv4 transmit framer: prepends a 20-byte IPv4 header to an L4 byte stream.
//   clk, rst_n          : clock, synchronous active-low reset
//   start, start_ready  : packet request handshake (ready only when idle)
//   l4_len, src_ip, dst_ip : header fields sampled when a request is accepted
//   s_data/s_valid/s_last/s_ready : L4 byte stream in
//   m_data/m_valid/m_last/m_ready : IPv4 byte stream out
module ipv4_tx_framer
  import ipv4_tx_framer_pkg::*;
#(
  parameter logic [15:0] ID         = 16'h0000,
  parameter logic [15:0] FLAGS_FRAG = 16'h4000,
  parameter logic [7:0]  TTL        = 8'h40,
  parameter logic [7:0]  PROTOCOL   = 8'h11
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        start_ready,
  input  logic [15:0] l4_len,
  input  logic [31:0] src_ip,
  input  logic [31:0] dst_ip,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  input  logic        s_last,
  output logic        s_ready,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready
);

  localparam logic [1:0] CSUM_LOAD = 2'(CSUM_LAT - 1);
  localparam logic [4:0] LAST_IDX  = 5'(HDR_BYTES - 1);

  state_t      state_q, state_d;
  logic [1:0]  cnt_q;
  logic [4:0]  hdr_idx_q;
  logic [7:0]  m_data_q;
  logic [15:0] total_len_q;
  logic [31:0] src_q, dst_q;

  logic [15:0] csum;
  logic [15:0] csum_in [HDR_WORDS-1];
  logic [15:0] hdr_w   [HDR_WORDS];
  logic [4:0]  next_idx;
  logic [7:0]  next_byte;

  // Checksum inputs are taken straight from the latched fields rather than
  // from hdr_w, so the registered checksum never feeds back into itself.
  always_comb begin
    csum_in[0] = VER_IHL;
    csum_in[1] = total_len_q;
    csum_in[2] = ID;
    csum_in[3] = FLAGS_FRAG;
    csum_in[4] = {TTL, PROTOCOL};
    csum_in[5] = src_q[31:16];
    csum_in[6] = src_q[15:0];
    csum_in[7] = dst_q[31:16];
    csum_in[8] = dst_q[15:0];
  end

  ipv4_hdr_csum u_csum (
    .clk    (clk),
    .rst_n  (rst_n),
    .fields (csum_in),
    .csum   (csum)
  );

  always_comb begin
    hdr_w[0] = VER_IHL;
    hdr_w[1] = total_len_q;
    hdr_w[2] = ID;
    hdr_w[3] = FLAGS_FRAG;
    hdr_w[4] = {TTL, PROTOCOL};
    hdr_w[5] = csum;
    hdr_w[6] = src_q[31:16];
    hdr_w[7] = src_q[15:0];
    hdr_w[8] = dst_q[31:16];
    hdr_w[9] = dst_q[15:0];
  end

  // m_data is registered in HDR, so the byte after the current one is
  // preloaded on each header transfer.
  always_comb begin
    next_idx  = hdr_idx_q + 5'd1;
    next_byte = '0;
    if (next_idx < 5'(HDR_BYTES))
      next_byte = word_byte(hdr_w[next_idx[4:1]], next_idx[0]);
  end

  always_comb begin
    state_d     = state_q;
    start_ready = 1'b0;
    s_ready     = 1'b0;
    m_valid     = 1'b0;
    m_last      = 1'b0;
    m_data      = m_data_q;
    unique case (state_q)
      ST_IDLE: begin
        start_ready = 1'b1;
        if (start) state_d = ST_CSUM;
      end
      ST_CSUM: begin
        if (cnt_q == '0) state_d = ST_HDR;
      end
      ST_HDR: begin
        m_valid = 1'b1;
        if (m_ready && hdr_idx_q == LAST_IDX) state_d = ST_PAYLOAD;
      end
      ST_PAYLOAD: begin
        m_data  = s_data;
        m_valid = s_valid;
        m_last  = s_last;
        s_ready = m_ready;
        if (s_valid && m_ready && s_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      hdr_idx_q   <= '0;
      m_data_q    <= '0;
      total_len_q <= '0;
      src_q       <= '0;
      dst_q       <= '0;
    end else begin
      state_q <= state_d;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            total_len_q <= l4_len + IP_HDR_LEN;
            src_q       <= src_ip;
            dst_q       <= dst_ip;
            cnt_q       <= CSUM_LOAD;
          end
        end
        ST_CSUM: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 2'd1;
          end else begin
            hdr_idx_q <= '0;
            m_data_q  <= word_byte(VER_IHL, 1'b0);
          end
        end
        ST_HDR: begin
          if (m_ready) begin
            if (hdr_idx_q == LAST_IDX) begin
              hdr_idx_q <= '0;
            end else begin
              hdr_idx_q <= next_idx;
              m_data_q  <= next_byte;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ipv4_tx_framer.sv
module tb_ipv4_tx_framer;

  localparam logic [15:0] ID_P    = 16'h0000;
  localparam logic [15:0] FLAGS_P = 16'h4000;
  localparam logic [7:0]  TTL_P   = 8'h40;
  localparam logic [7:0]  PROTO_P = 8'h11;
  localparam logic [31:0] SRC     = 32'hC0A80001;
  localparam logic [31:0] DST     = 32'hC0A800C7;

  logic        clk = 1'b0;
  logic        rst_n, start, start_ready;
  logic [15:0] l4_len;
  logic [31:0] src_ip, dst_ip;
  logic [7:0]  s_data, m_data;
  logic        s_valid, s_last, s_ready;
  logic        m_valid, m_last, m_ready;

  always #5 clk = ~clk;

  ipv4_tx_framer #(
    .ID(ID_P), .FLAGS_FRAG(FLAGS_P), .TTL(TTL_P), .PROTOCOL(PROTO_P)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_ready(start_ready),
    .l4_len(l4_len), .src_ip(src_ip), .dst_ip(dst_ip),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .m_data(m_data), .m_valid(m_valid), .m_last(m_last), .m_ready(m_ready)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [9:0]  exp_q [$];      // {is_header, last, data}
  logic [7:0]  cap [256];
  int          cap_n    = 0;
  int          last_cnt = 0;
  bit          rnd_ready = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  function automatic logic [15:0] model_csum(input logic [15:0] tl,
                                             input logic [31:0] s, input logic [31:0] d);
    logic [31:0] sum;
    sum = 32'h4500;
    sum += tl;
    sum += ID_P;
    sum += FLAGS_P;
    sum += {TTL_P, PROTO_P};
    sum += s[31:16];
    sum += s[15:0];
    sum += d[31:16];
    sum += d[15:0];
    while ((sum >> 16) != 0) sum = (sum & 32'hFFFF) + (sum >> 16);
    return ~sum[15:0];
  endfunction

  function automatic logic [7:0] pay_byte(input int seed, input int i);
    return 8'((seed + i * 13) & 255);
  endfunction

  task automatic push_pkt(input logic [15:0] l4, input logic [31:0] s,
                          input logic [31:0] d, input int npay, input int seed);
    logic [15:0] tl;
    logic [15:0] w [10];
    logic [7:0]  b;
    tl = l4 + 16'd20;
    w[0] = 16'h4500; w[1] = tl; w[2] = ID_P; w[3] = FLAGS_P;
    w[4] = {TTL_P, PROTO_P}; w[5] = model_csum(tl, s, d);
    w[6] = s[31:16]; w[7] = s[15:0]; w[8] = d[31:16]; w[9] = d[15:0];
    for (int i = 0; i < 20; i++) begin
      b = (i % 2 == 0) ? w[i/2][15:8] : w[i/2][7:0];
      exp_q.push_back({1'b1, 1'b0, b});
    end
    for (int i = 0; i < npay; i++)
      exp_q.push_back({1'b0, (i == npay - 1), pay_byte(seed, i)});
  endtask

  task automatic do_start(input logic [15:0] l4, input logic [31:0] s, input logic [31:0] d);
    bit ok;
    ok = 1'b0;
    l4_len = l4; src_ip = s; dst_ip = d; start = 1'b1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (start_ready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    start = 1'b0;
    check("start_accept", ok, 1);
  endtask

  task automatic stream(input int npay, input int seed, input bit hold_start,
                        input logic [15:0] nl4);
    int  i, guard;
    bit  fire;
    i = 0; guard = 0;
    while (i < npay && guard < 5000) begin
      s_valid = 1'b1;
      s_data  = pay_byte(seed, i);
      s_last  = (i == npay - 1);
      if (hold_start && i == npay - 1) begin
        start = 1'b1; l4_len = nl4; src_ip = SRC; dst_ip = DST;
      end
      @(negedge clk);
      fire = s_valid && s_ready;
      @(posedge clk); #1;
      if (fire) i++;
      guard++;
    end
    s_valid = 1'b0; s_last = 1'b0;
    check("stream_done", i, npay);
  endtask

  task automatic wait_cap(input int n);
    for (int k = 0; k < 500 && cap_n < n; k++) begin @(posedge clk); #1; end
    check("wait_cap", (cap_n >= n), 1);
  endtask

  // Cycle-by-cycle compare against the expected byte stream.
  always @(negedge clk) begin
    logic [9:0] e;
    if (rst_n) begin
      if (exp_q.size() > 0 && exp_q[0][9]) check("s_ready_in_hdr", s_ready, 0);
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) check("extra_byte", 1, 0);
        else begin
          e = exp_q.pop_front();
          check("m_data", m_data, e[7:0]);
          check("m_last", m_last, e[8]);
        end
        if (cap_n < 256) cap[cap_n] = m_data;
        cap_n++;
        if (m_last) last_cnt++;
      end
    end
  end

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      m_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  logic [7:0] lit [20];

  initial begin
    lit = '{8'h45, 8'h00, 8'h00, 8'h73, 8'h00, 8'h00, 8'h40, 8'h00, 8'h40, 8'h11,
            8'hB8, 8'h61, 8'hC0, 8'hA8, 8'h00, 8'h01, 8'hC0, 8'hA8, 8'h00, 8'hC7};
    rst_n = 1'b0; start = 1'b0; l4_len = '0; src_ip = '0; dst_ip = '0;
    s_data = '0; s_valid = 1'b0; s_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    s_valid = 1'b1;   // must have no effect while idle
    @(negedge clk);
    check("rst_start_ready", start_ready, 1);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 0);
    check("rst_s_ready", s_ready, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; s_valid = 1'b0;

    // Reference packet, full readiness
    cap_n = 0; last_cnt = 0;
    push_pkt(16'd95, SRC, DST, 95, 1);
    do_start(16'd95, SRC, DST);
    stream(95, 1, 1'b0, 16'd0);
    repeat (5) @(posedge clk); #1;
    check("pkt1_len", cap_n, 115);
    check("pkt1_last_cnt", last_cnt, 1);
    for (int i = 0; i < 20; i++) check("pkt1_hdr_lit", cap[i], lit[i]);
    check("pkt1_idle", start_ready, 1);

    // Same packet, random backpressure
    cap_n = 0; last_cnt = 0; rnd_ready = 1'b1;
    push_pkt(16'd95, SRC, DST, 95, 1);
    do_start(16'd95, SRC, DST);
    stream(95, 1, 1'b0, 16'd0);
    rnd_ready = 1'b0;
    repeat (5) @(posedge clk); #1;
    check("pkt2_len", cap_n, 115);
    check("pkt2_last_cnt", last_cnt, 1);
    for (int i = 0; i < 20; i++) check("pkt2_hdr_lit", cap[i], lit[i]);

    // start pulses during HDR and PAYLOAD must be ignored
    cap_n = 0; last_cnt = 0;
    push_pkt(16'd40, SRC, DST, 40, 3);
    do_start(16'd40, SRC, DST);
    fork
      stream(40, 3, 1'b0, 16'd0);
      begin
        wait_cap(5);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
        wait_cap(25);
        start = 1'b1; @(posedge clk); #1; start = 1'b0;
      end
    join
    repeat (20) @(posedge clk); #1;
    check("ign_len", cap_n, 60);
    check("ign_last_cnt", last_cnt, 1);
    check("ign_q_empty", exp_q.size(), 0);

    // Reset while header byte 7 is on the output
    cap_n = 0; last_cnt = 0;
    push_pkt(16'd95, SRC, DST, 95, 7);
    do_start(16'd95, SRC, DST);
    wait_cap(7);
    rst_n = 1'b0;
    exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_m_valid", m_valid, 0);
    check("rst_mid_m_last", m_last, 0);
    check("rst_mid_start_ready", start_ready, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    check("rst_mid_no_last", last_cnt, 0);
    cap_n = 0; last_cnt = 0;
    push_pkt(16'd8, SRC, DST, 8, 9);
    do_start(16'd8, SRC, DST);
    stream(8, 9, 1'b0, 16'd0);
    repeat (5) @(posedge clk); #1;
    check("rst_next_len", cap_n, 28);
    check("rst_next_b0", cap[0], 8'h45);
    check("rst_next_tl_hi", cap[2], 8'h00);
    check("rst_next_tl_lo", cap[3], 8'h1C);
    check("rst_next_cs_hi", cap[10], 8'hB8);
    check("rst_next_cs_lo", cap[11], 8'hB8);
    check("rst_next_last_cnt", last_cnt, 1);

    // total_len wrap, then back-to-back start into an l4_len=0 packet
    cap_n = 0; last_cnt = 0;
    push_pkt(16'hFFF0, SRC, DST, 4, 11);
    do_start(16'hFFF0, SRC, DST);
    stream(4, 11, 1'b1, 16'd0);
    push_pkt(16'd0, SRC, DST, 1, 13);
    @(negedge clk);
    check("b2b_idle", start_ready, 1);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check("b2b_accepted", start_ready, 0);
    @(posedge clk); #1;
    stream(1, 13, 1'b0, 16'd0);
    repeat (5) @(posedge clk); #1;
    check("wrap_tl_hi", cap[2], 8'h00);
    check("wrap_tl_lo", cap[3], 8'h04);
    check("wrap_cs_hi", cap[10], 8'hB8);
    check("wrap_cs_lo", cap[11], 8'hD0);
    check("zero_tl_hi", cap[26], 8'h00);
    check("zero_tl_lo", cap[27], 8'h14);
    check("wrap_zero_len", cap_n, 45);
    check("wrap_zero_last_cnt", last_cnt, 2);
    check("final_q_empty", exp_q.size(), 0);
    check("final_idle", start_ready, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
